// File: rtl/big_core_pkg.sv
// Shared big_core definitions: CR keyboard register map, keyboard bus payloads,
// and the keyboard receiver state enum (exposed so benches can probe it).
package big_core_pkg;

    localparam int unsigned KBD_DATA_W = 8;
    localparam int unsigned KBD_WORD_W = 11;

    // CR register addresses for the keyboard interface
    localparam logic [7:0] CR_KBD_DATA     = 8'h40;
    localparam logic [7:0] CR_KBD_READY    = 8'h41;
    localparam logic [7:0] CR_KBD_SCANF_EN = 8'h42;

    // One deframed PS/2 word, in the order the bits arrive on the wire
    typedef struct packed {
        logic                  start;
        logic [KBD_DATA_W-1:0] data;
        logic                  odd_parity;
        logic                  stop;
    } t_kbd_word;

    // Receiver -> CR read payload
    typedef struct packed {
        logic [KBD_DATA_W-1:0] kbd_data;
        logic                  kbd_ready;
    } t_kbd_data_rd;

    // CR -> receiver control payload
    typedef struct packed {
        logic kbd_scanf_en;
        logic kbd_pop;
    } t_kbd_ctrl;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } t_kbd_rx_state;

    // Start low, stop high, and an odd number of ones across data+parity
    function automatic logic kbd_word_valid(input t_kbd_word w);
        return (~w.start) & w.stop & (^{w.data, w.odd_parity});
    endfunction

endpackage

// File: rtl/big_core_kbd_fifo.sv
// Scan-code FIFO for the keyboard receiver.
// Ports: Clk/Rst (sync, active-high); i_push/i_wdata write side; i_pop read side;
// o_head registered head entry (0 when empty); o_full/o_empty registered flags.
// Push while full is ignored unless a pop in the same cycle frees a slot;
// pop while empty is ignored.
module big_core_kbd_fifo #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DATA_W     = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic              o_full,
    output logic              o_empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_wr_ptr;
    logic [DATA_W-1:0] r_head;
    logic              r_full;
    logic              r_empty;

    logic [PW-1:0]     w_rd_nxt;
    logic [PW-1:0]     w_wr_nxt;
    logic [DATA_W-1:0] w_head_nxt;
    logic              w_do_push;
    logic              w_do_pop;
    logic              w_full_nxt;
    logic              w_empty_nxt;

    // Next pointers/flags and look-ahead head so outputs stay registered
    always_comb begin
        w_do_pop    = i_pop & ~r_empty;
        w_do_push   = i_push & (~r_full | w_do_pop);
        w_rd_nxt    = r_rd_ptr + PW'(w_do_pop);
        w_wr_nxt    = r_wr_ptr + PW'(w_do_push);
        w_empty_nxt = (w_rd_nxt == w_wr_nxt);
        w_full_nxt  = (w_rd_nxt[AW-1:0] == w_wr_nxt[AW-1:0]) &&
                      (w_rd_nxt[AW] != w_wr_nxt[AW]);
        w_head_nxt  = '0;
        if (!w_empty_nxt) begin
            // New head is the word being written this cycle when it lands in the head slot
            if (w_do_push && (w_rd_nxt[AW-1:0] == r_wr_ptr[AW-1:0])) begin
                w_head_nxt = i_wdata;
            end else begin
                w_head_nxt = r_mem[w_rd_nxt[AW-1:0]];
            end
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge Clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    // Pointers and registered outputs
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_head   <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_rd_ptr <= w_rd_nxt;
            r_wr_ptr <= w_wr_nxt;
            r_head   <= w_head_nxt;
            r_full   <= w_full_nxt;
            r_empty  <= w_empty_nxt;
        end
    end

    assign o_head  = r_head;
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/big_core_kbd_rx.sv
// PS/2 keyboard receiver feeding the CR keyboard registers.
// Ports: Clk/Rst (sync, active-high); kbd_clk/kbd_dat asynchronous PS/2 lines;
// kbd_ctrl {scanf_en, pop} from CR; kbd_data_rd {FIFO head, not-empty} to CR;
// kbd_overflow sticky drop flag; kbd_frame_err one-cycle error/timeout pulse.
module big_core_kbd_rx
    import big_core_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         kbd_clk,
    input  logic         kbd_dat,
    input  t_kbd_ctrl    kbd_ctrl,
    output t_kbd_data_rd kbd_data_rd,
    output logic         kbd_overflow,
    output logic         kbd_frame_err
);

    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;
    t_kbd_rx_state          r_state;
    logic [3:0]             r_bit_cnt;
    logic [KBD_WORD_W-1:0]  r_shift;
    logic [TO_W-1:0]        r_to_cnt;
    logic                   r_frame_err;
    logic                   r_overflow;

    t_kbd_rx_state          w_state_nxt;
    logic [3:0]             w_bit_cnt_nxt;
    logic [KBD_WORD_W-1:0]  w_shift_nxt;
    logic [TO_W-1:0]        w_to_cnt_nxt;
    logic                   w_err_nxt;
    logic                   w_push;
    logic                   w_fall;
    logic                   w_sample;
    t_kbd_word              w_word;
    logic [KBD_DATA_W-1:0]  w_head;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;

    // Input synchronisers; preset high so reset never fakes a falling edge
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], kbd_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], kbd_dat};
            r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
        end
    end

    assign w_fall   = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
    assign w_sample = r_dat_sync[SYNC_STAGES-1];

    // Bits enter at the MSB, so the first-received (start) bit ends up at bit 0
    always_comb begin
        w_word.start      = r_shift[0];
        w_word.data       = r_shift[8:1];
        w_word.odd_parity = r_shift[9];
        w_word.stop       = r_shift[10];
    end

    // State register and datapath registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_to_cnt    <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
            r_frame_err <= w_err_nxt;
        end
    end

    // Deframing FSM: next state, shift, timeout and push decision
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_to_cnt_nxt  = r_to_cnt;
        w_err_nxt     = 1'b0;
        w_push        = 1'b0;
        case (r_state)
            IDLE: begin
                w_bit_cnt_nxt = '0;
                w_to_cnt_nxt  = '0;
                if (w_fall) begin
                    if (!w_sample) begin
                        w_state_nxt   = RECV;
                        w_bit_cnt_nxt = 4'd1;
                        w_shift_nxt   = {w_sample, r_shift[KBD_WORD_W-1:1]};
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            RECV: begin
                if (w_fall) begin
                    w_shift_nxt   = {w_sample, r_shift[KBD_WORD_W-1:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    w_to_cnt_nxt  = '0;
                    if (r_bit_cnt == 4'd10) begin
                        w_state_nxt = CHECK;
                    end
                end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt = IDLE;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                end
            end
            CHECK: begin
                w_state_nxt = IDLE;
                if (!kbd_word_valid(w_word)) begin
                    w_err_nxt = 1'b1;
                end else if (kbd_ctrl.kbd_scanf_en) begin
                    w_push = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Sticky overflow: a valid frame found no room and no pop freed one
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_fifo_full && !kbd_ctrl.kbd_pop) begin
            r_overflow <= 1'b1;
        end
    end

    big_core_kbd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (KBD_DATA_W)
    ) u_fifo (
        .Clk     (Clk),
        .Rst     (Rst),
        .i_push  (w_push),
        .i_wdata (w_word.data),
        .i_pop   (kbd_ctrl.kbd_pop),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign kbd_data_rd.kbd_data  = w_head;
    assign kbd_data_rd.kbd_ready = ~w_fifo_empty;
    assign kbd_overflow          = r_overflow;
    assign kbd_frame_err         = r_frame_err;

endmodule

// File: tb/tb_big_core_kbd_rx.sv
// Directed bench for big_core_kbd_rx with a queue-based reference model that
// is checked against the DUT outputs every cycle, plus literal spot checks.
module tb_big_core_kbd_rx;
    import big_core_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned TO    = 1000;
    localparam int          HALF  = 8;
    localparam int          EV_PUSH = 1;
    localparam int          EV_ERR  = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         kbd_clk = 1'b1;
    logic         kbd_dat = 1'b1;
    t_kbd_ctrl    ctrl;
    t_kbd_data_rd rd;
    logic         ovf;
    logic         ferr;

    int n_vec = 0;
    int n_mis = 0;
    int cyc = 0;

    byte unsigned m_q[$];
    logic         m_ovf = 1'b0;
    logic         m_err = 1'b0;
    int           ev_cyc = -1;
    int           ev_kind = 0;
    byte unsigned ev_data = 8'h00;
    bit           cmp_en = 1'b0;
    int           rise_cyc = -1;
    logic         prev_ready = 1'b0;
    int           n_ferr = 0;
    int           last_fall = 0;

    always #5 clk = ~clk;

    big_core_kbd_rx #(
        .FIFO_DEPTH     (DEPTH),
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .Clk           (clk),
        .Rst           (rst),
        .kbd_clk       (kbd_clk),
        .kbd_dat       (kbd_dat),
        .kbd_ctrl      (ctrl),
        .kbd_data_rd   (rd),
        .kbd_overflow  (ovf),
        .kbd_frame_err (ferr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle counter: value p is seen for the whole cycle after posedge p
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference model and per-cycle compare: check outputs of this cycle,
    // then advance the model using the inputs the DUT samples at the next edge
    initial begin
        bit           do_pop;
        logic [7:0]   exp_data;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                exp_data = (m_q.size() > 0) ? m_q[0] : 8'h00;
                chk("ready", 32'(rd.kbd_ready), 32'(m_q.size() > 0));
                chk("data", 32'(rd.kbd_data), 32'(exp_data));
                chk("overflow", 32'(ovf), 32'(m_ovf));
                chk("frame_err", 32'(ferr), 32'(m_err));
            end
            if (ferr === 1'b1) n_ferr++;
            if (rd.kbd_ready === 1'b1 && prev_ready !== 1'b1) rise_cyc = cyc;
            prev_ready = rd.kbd_ready;
            if (rst) begin
                m_q.delete();
                m_ovf = 1'b0;
                m_err = 1'b0;
                ev_cyc = -1;
            end else begin
                m_err = 1'b0;
                do_pop = ctrl.kbd_pop && (m_q.size() > 0);
                if (do_pop) void'(m_q.pop_front());
                if (ev_cyc == cyc + 1) begin
                    if (ev_kind == EV_ERR) begin
                        m_err = 1'b1;
                    end else if (ctrl.kbd_scanf_en) begin
                        if (m_q.size() == int'(DEPTH)) m_ovf = 1'b1;
                        else m_q.push_back(ev_data);
                    end
                    ev_cyc = -1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Full 11-bit frame; result lands SYNC+2 edges after the stop-bit fall
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit pop_chk);
        logic [10:0] b;
        b[0]   = 1'b0;
        b[8:1] = d;
        b[9]   = ((($countones(d) % 2) == 0) ? 1'b1 : 1'b0) ^ bad_par;
        b[10]  = 1'b1;
        for (int i = 0; i < 11; i++) begin
            kbd_dat = b[i];
            tick(HALF);
            kbd_clk = 1'b0;
            last_fall = cyc;
            if (i == 10) begin
                ev_data = d;
                ev_kind = bad_par ? EV_ERR : EV_PUSH;
                ev_cyc  = cyc + SYNC + 2;
            end
            if (i == 10 && pop_chk) begin
                tick(SYNC + 1);
                ctrl.kbd_pop = 1'b1;
                tick(1);
                ctrl.kbd_pop = 1'b0;
                tick(HALF - SYNC - 2);
            end else begin
                tick(HALF);
            end
            kbd_clk = 1'b1;
        end
        kbd_dat = 1'b1;
        tick(2 * HALF);
    endtask

    // First n bits of a frame, then the lines are left idle-high on the clock
    task automatic send_partial(input logic [7:0] d, input int n);
        logic [10:0] b;
        b      = 11'h400;
        b[8:1] = d;
        for (int i = 0; i < n; i++) begin
            kbd_dat = b[i];
            tick(HALF);
            kbd_clk = 1'b0;
            last_fall = cyc;
            tick(HALF);
            kbd_clk = 1'b1;
        end
    endtask

    task automatic pop1();
        ctrl.kbd_pop = 1'b1;
        tick(1);
        ctrl.kbd_pop = 1'b0;
    endtask

    initial begin
        int e0;
        ctrl.kbd_scanf_en = 1'b1;
        ctrl.kbd_pop      = 1'b0;
        tick(3);
        chk("reset ready", 32'(rd.kbd_ready), 32'h0);
        chk("reset data", 32'(rd.kbd_data), 32'h0);
        chk("reset overflow", 32'(ovf), 32'h0);
        chk("reset frame_err", 32'(ferr), 32'h0);
        chk("reset state", 32'(dut.r_state), 32'(IDLE));
        rst = 1'b0;
        cmp_en = 1'b1;
        tick(4);

        // Single frame 0x1C: ready two cycles after the stop fall is detected
        rise_cyc = -1;
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("ready latency", 32'(rise_cyc), 32'(last_fall + 4));
        chk("single data", 32'(rd.kbd_data), 32'h1C);
        pop1();
        chk("pop empties ready", 32'(rd.kbd_ready), 32'h0);
        chk("pop empties data", 32'(rd.kbd_data), 32'h0);

        // Wrong parity
        e0 = n_ferr;
        send_frame(8'h1C, 1'b1, 1'b0);
        chk("bad parity err pulses", 32'(n_ferr - e0), 32'd1);
        chk("bad parity ready", 32'(rd.kbd_ready), 32'h0);

        // scanf disabled then enabled
        e0 = n_ferr;
        ctrl.kbd_scanf_en = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b0);
        ctrl.kbd_scanf_en = 1'b1;
        send_frame(8'h29, 1'b0, 1'b0);
        chk("scanf data", 32'(rd.kbd_data), 32'h29);
        chk("scanf err pulses", 32'(n_ferr - e0), 32'd0);
        chk("scanf overflow", 32'(ovf), 32'h0);
        pop1();
        chk("scanf single entry", 32'(rd.kbd_ready), 32'h0);

        // Timeout of a partial frame, then recovery
        e0 = n_ferr;
        send_partial(8'h76, 5);
        ev_kind = EV_ERR;
        ev_cyc  = last_fall + SYNC + 1 + TO;
        tick(TO + 20);
        chk("timeout err pulses", 32'(n_ferr - e0), 32'd1);
        chk("timeout state", 32'(dut.r_state), 32'(IDLE));
        kbd_dat = 1'b1;
        send_frame(8'h76, 1'b0, 1'b0);
        chk("after timeout data", 32'(rd.kbd_data), 32'h76);
        pop1();

        // Fall with data high while idle is a bad start bit
        e0 = n_ferr;
        kbd_dat = 1'b1;
        tick(HALF);
        kbd_clk = 1'b0;
        ev_kind = EV_ERR;
        ev_cyc  = cyc + SYNC + 1;
        tick(HALF);
        kbd_clk = 1'b1;
        tick(2 * HALF);
        chk("bad start err pulses", 32'(n_ferr - e0), 32'd1);

        // Nine frames into an eight-deep FIFO
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
        chk("nine overflow", 32'(ovf), 32'h1);
        for (int i = 1; i <= 8; i++) begin
            chk("pop order", 32'(rd.kbd_data), 32'(i));
            pop1();
        end
        chk("drained ready", 32'(rd.kbd_ready), 32'h0);
        chk("overflow sticky", 32'(ovf), 32'h1);

        // Reset, fill, then pop during CHECK of 0x33
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("reset clears overflow", 32'(ovf), 32'h0);
        for (int i = 0; i < 8; i++) send_frame(8'h40 + 8'(i), 1'b0, 1'b0);
        send_frame(8'h33, 1'b0, 1'b1);
        chk("pop in check overflow", 32'(ovf), 32'h0);
        for (int i = 1; i < 8; i++) begin
            chk("full pop order", 32'(rd.kbd_data), 32'h40 + 32'(i));
            pop1();
        end
        chk("last entry", 32'(rd.kbd_data), 32'h33);

        // Reset in the middle of a frame
        send_partial(8'h55, 4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midframe rst ready", 32'(rd.kbd_ready), 32'h0);
        chk("midframe rst data", 32'(rd.kbd_data), 32'h0);
        chk("midframe rst overflow", 32'(ovf), 32'h0);
        chk("midframe rst frame_err", 32'(ferr), 32'h0);
        chk("midframe rst state", 32'(dut.r_state), 32'(IDLE));
        kbd_dat = 1'b1;
        tick(TO + 20);
        send_frame(8'h12, 1'b0, 1'b0);
        chk("after reset data", 32'(rd.kbd_data), 32'h12);
        tick(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/big_core_kbd_rx.md
Name: big_core_kbd_rx

Overview:
- PS/2 keyboard receiver that feeds the big_core CR block's keyboard registers (CR_KBD_DATA, CR_KBD_READY, CR_KBD_SCANF_EN).
- Oversamples the asynchronous PS/2 clock and data lines on the core clock and deframes 11-bit words (start, 8 data bits LSB first, odd parity, stop).
- Buffers valid scan codes in a small FIFO and presents the head entry to CR through t_kbd_data_rd. Accepts scanf-enable and pop controls from CR through t_kbd_ctrl.

Parameters:
- FIFO_DEPTH, 8, number of scan-code entries; must be a power of two, at least 2.
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser for kbd_clk and kbd_dat.
- TIMEOUT_CYCLES, 50000, core-clock cycles without a PS/2 falling edge before a partial frame is abandoned.

Ports:
- Clk  input  1  core clock.
- Rst  input  1  synchronous reset, active-high.
- kbd_clk  input  1  PS/2 clock line; asynchronous, idles high.
- kbd_dat  input  1  PS/2 data line; asynchronous, idles high.
- kbd_ctrl  input  t_kbd_ctrl  kbd_scanf_en (level) and kbd_pop (one-cycle pulse) from CR.
- kbd_data_rd  output  t_kbd_data_rd  kbd_data = FIFO head; kbd_ready = FIFO not empty.
- kbd_overflow  output  1  sticky flag: a valid frame was dropped because the FIFO was full.
- kbd_frame_err  output  1  one-cycle pulse on a start, stop, or parity error, or on a timeout.

Behaviour:
- Clocking and reset: single Clk domain. Reset is synchronous and active-high. The clock and reset ports are named Clk and Rst.
- Reset values:
  - Synchroniser flops are set to 1, so no false edge appears after reset.
  - FSM goes to IDLE; bit counter, shift register, and timeout counter are cleared to 0.
  - FIFO is empty; kbd_data = 0, kbd_ready = 0, kbd_overflow = 0, kbd_frame_err = 0.
- Reset asserted mid-frame discards the partial frame. FIFO contents are lost.
- Edge detect: fall = sync_clk_prev & ~sync_clk. Synchronised data is sampled in the same cycle as fall.
- FSM states:
  - IDLE: on fall with sample 0, go to RECV with bit_cnt = 1. On fall with sample 1, stay in IDLE and pulse kbd_frame_err.
  - RECV: each fall shifts the sample into the shift register and increments bit_cnt. When the sample with bit_cnt = 10 (stop bit) is taken, go to CHECK.
  - CHECK: one cycle. valid = (start==0) & (stop==1) & (^{data,parity}==1). Always returns to IDLE.
- Frame assembly: shifted bits map onto t_kbd_word {start, data, odd_parity, stop}, with data[0] received first.
- Timeout: in RECV, the timeout counter resets on every fall. When it reaches TIMEOUT_CYCLES-1, go to IDLE, discard the frame, and pulse kbd_frame_err.
- Push rule, evaluated in CHECK:
  - Push only when valid & kbd_scanf_en.
  - If the FIFO is full and pop is not asserted in the same cycle, drop the frame and set kbd_overflow. kbd_overflow clears only on Rst.
  - If scanf_en is low, decoding continues (keeps frame alignment) but valid frames are discarded silently.
- Error frames are never pushed.
- Pop rule: kbd_pop with FIFO non-empty advances the read pointer. kbd_pop on an empty FIFO is ignored.
- Simultaneous push and pop:
  - Both take effect and the count is unchanged.
  - When full, the push is accepted because the pop frees a slot.
  - When empty, the pop is ignored and the push proceeds.
- Latency:
  - Stop-bit fall is detected in cycle N, CHECK is cycle N+1, and the entry is written at the end of N+1.
  - kbd_ready = 1 and kbd_data valid from cycle N+2.
  - After a pop in cycle M, the next head (or ready = 0) is visible at M+1.
- Outputs are registered.
  - kbd_data is 0 whenever the FIFO is empty.
  - Pointers are log2(FIFO_DEPTH) bits plus a wrap bit and wrap modulo FIFO_DEPTH.
  - full = pointers equal with wrap bits different; empty = pointers equal with wrap bits equal.
- The block does not change scanf_en on its own; CR owns that control.

Decomposition:
- Shared package big_core_pkg holds the following; this block adds no new typedefs:
  - t_kbd_word, t_kbd_data_rd, t_kbd_ctrl.
  - CR_KBD_DATA, CR_KBD_READY, CR_KBD_SCANF_EN.
- Local enum t_kbd_rx_state {IDLE, RECV, CHECK} goes in the package as well so the bench can probe state.
- One sub-module: big_core_kbd_fifo, a synchronous FIFO (8-bit wide, FIFO_DEPTH deep) with push, pop, head data, full, and empty.
- The synchroniser, edge detect, FSM, and timeout logic stay in big_core_kbd_rx.

Test Plan:
- Single frame 0x1C with parity 0, scanf_en = 1:
  - kbd_ready rises 2 cycles after the stop-bit falling edge; kbd_data = 0x1C.
  - A pop pulse gives kbd_ready = 0 and kbd_data = 0 on the next cycle.
- Frame 0x1C with parity 1 (wrong): kbd_frame_err pulses once, FIFO stays empty, kbd_ready stays 0.
- 9 valid frames 0x01..0x09 with no pops: FIFO holds 0x01..0x08, kbd_overflow = 1, and popping 8 times yields 0x01..0x08 in order.
- scanf_en = 0 during frame 0x5A, then 1 during frame 0x29: only 0x29 appears; no kbd_frame_err, no kbd_overflow.
- 5 bits of a frame followed by TIMEOUT_CYCLES of idle: kbd_frame_err pulses and the FSM is in IDLE. A following valid frame 0x76 is received correctly.
- FIFO full with kbd_pop asserted in the CHECK cycle of frame 0x33: kbd_overflow stays 0 and 0x33 becomes the last entry. Separately, Rst asserted mid-frame: all outputs 0 on the next cycle.
